// File: rtl/tdm_mux_16x1.sv
// rtl/tdm_mux_16x1.sv - sequential NCH:1 time-division multiplexer (frame serialiser)
//
// Purpose: accept one parallel frame (one bit per channel) over a valid/ready
// handshake, then present it one channel per slot on out_bit with the matching
// channel index on out_sel. Each slot is held for SLOT_CYCLES clocks.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_data      in   [NCH-1:0] parallel frame, bit i = channel i
//   in_valid     in   in_data valid
//   in_ready     out  frame can be accepted this cycle
//   out_bit      out  serial data of the current slot (frame[out_sel])
//   out_sel      out  [SELW-1:0] current channel index
//   out_valid    out  out_bit/out_sel meaningful
//   frame_start  out  pulse on the first cycle of slot 0
//   frame_done   out  pulse on the last cycle of slot NCH-1
//   busy         out  frame in progress
module tdm_mux_16x1 #(
    parameter int NCH         = 16,
    parameter int SELW        = $clog2(NCH),
    parameter int SLOT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_bit,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    output logic            frame_start,
    output logic            frame_done,
    output logic            busy
);

    localparam int CNTW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SLOT_CYCLES - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NCH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  frame_q, frame_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            out_bit_q, out_bit_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;
    logic            handshake;
    logic            shift_d;

    // A new frame is accepted either from IDLE or on the final cycle of the
    // frame in flight, which is what makes back-to-back frames gapless.
    assign in_ready  = rst_n & ((state_q == IDLE) | frame_done_q);
    assign handshake = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = SHIFT;
                    frame_d = in_data;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (frame_done_q) begin
                    sel_d = '0;
                    cnt_d = '0;
                    if (handshake) begin
                        frame_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    sel_d = sel_q + SELW'(1);
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are computed from the next-state view.
        shift_d       = (state_d == SHIFT);
        out_valid_d   = shift_d;
        busy_d        = shift_d;
        out_bit_d     = shift_d & frame_d[sel_d];
        frame_start_d = handshake;
        frame_done_d  = shift_d && (sel_d == SEL_LAST) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            out_bit_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            out_bit_q     <= out_bit_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign out_bit     = out_bit_q;
    assign out_sel     = sel_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule
